// File: rtl/s2p_lane_deskew_pkg.sv
// Shared definitions for the 4-lane deskew block.
//   COM_SYM    : alignment symbol that marks the same byte position on every lane
//   NUM_LANES  : number of captured lanes (fixed at 4)
//   state_e    : supervisor FSM encoding (1 bit)
//   cnt_width  : width helper for counters that must hold values 0..max_val
package s2p_lane_deskew_pkg;

  localparam logic [7:0] COM_SYM   = 8'hBC;
  localparam int         NUM_LANES = 4;

  typedef enum logic {
    ST_SEARCH = 1'b0,
    ST_LOCKED = 1'b1
  } state_e;

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/s2p_lane_deskew_if.sv
// Bus between the s2p capture stage and the deskew block.
//   ENB        global enable, low freezes the block
//   BYTE_VLD   one-cycle strobe: Q0..Q3 carry a new captured byte per lane
//   Q0..Q3     captured lane bytes
//   DATA_OUT   aligned word {lane3,lane2,lane1,lane0}
//   VALID_OUT  one-cycle pulse qualifying DATA_OUT
//   LOCKED     alignment achieved
//   ERR        one-cycle pulse, emitted word had COM on some but not all lanes
//
// Handshake: there is no back-pressure. A byte is consumed on every clock
// where BYTE_VLD & ENB is high; a word is delivered on every clock where
// VALID_OUT is high and the sink must take it then. ERR is only ever high
// together with VALID_OUT and describes the word presented with it.
interface s2p_lane_deskew_if;
  logic        ENB;
  logic        BYTE_VLD;
  logic [7:0]  Q0;
  logic [7:0]  Q1;
  logic [7:0]  Q2;
  logic [7:0]  Q3;
  logic [31:0] DATA_OUT;
  logic        VALID_OUT;
  logic        LOCKED;
  logic        ERR;

  modport master (
    output ENB, BYTE_VLD, Q0, Q1, Q2, Q3,
    input  DATA_OUT, VALID_OUT, LOCKED, ERR
  );

  modport slave (
    input  ENB, BYTE_VLD, Q0, Q1, Q2, Q3,
    output DATA_OUT, VALID_OUT, LOCKED, ERR
  );
endinterface

// File: rtl/s2p_lane_buf.sv
// One lane of the deskew block: byte shift buffer, COM seen flag + age
// counter used while searching, and the frozen tap that selects the
// aligned byte once locked.
//   clk, reset  : clock, synchronous active-high reset
//   strobe      : a new byte is present on q (already gated by enable)
//   search_upd  : strobe while the supervisor is searching
//   restart     : some lane overflowed; reseed seen/age from this byte only
//   lock        : supervisor locks on this strobe; capture tap
//   clr_seen    : forget seen/age (loss of lock or lock taken)
//   q           : incoming lane byte
//   seen_new    : seen flag after this strobe's update
//   ovf         : this lane's age would pass MAX_SKEW on the next strobe
//   byte_out    : aligned byte, buffer[tap] after the shift
module s2p_lane_buf
  import s2p_lane_deskew_pkg::*;
#(
  parameter int         MAX_SKEW = 3,
  parameter logic [7:0] COM      = COM_SYM
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       strobe,
  input  logic       search_upd,
  input  logic       restart,
  input  logic       lock,
  input  logic       clr_seen,
  input  logic [7:0] q,
  output logic       seen_new,
  output logic       ovf,
  output logic [7:0] byte_out
);

  localparam int AW = cnt_width(MAX_SKEW + 1);

  logic [MAX_SKEW:0][7:0] sr_q, sr_d;
  logic                   seen_q, seen_d;
  logic [AW-1:0]          age_q, age_d;
  logic [AW-1:0]          tap_q, tap_d;
  logic [AW-1:0]          age_new;
  logic [AW-1:0]          sel;
  logic                   is_com;

  always_comb begin
    is_com   = (q == COM);
    // A restart throws away history, so only this strobe's byte counts.
    seen_new = restart ? is_com : (seen_q | is_com);
    age_new  = (restart || !seen_q) ? '0 : age_q + AW'(1);
    ovf      = seen_q && (age_q == AW'(MAX_SKEW));

    sr_d   = sr_q;
    seen_d = seen_q;
    age_d  = age_q;
    tap_d  = tap_q;

    if (strobe) begin
      sr_d[0] = q;
      for (int i = 1; i <= MAX_SKEW; i++) begin
        sr_d[i] = sr_q[i-1];
      end
    end

    if (clr_seen) begin
      seen_d = 1'b0;
      age_d  = '0;
    end else if (search_upd) begin
      seen_d = seen_new;
      age_d  = age_new;
    end

    if (lock) begin
      tap_d = age_new;
    end

    // The locking strobe must already use the new tap so its word is all COM.
    sel      = lock ? age_new : tap_q;
    byte_out = '0;
    for (int i = 0; i <= MAX_SKEW; i++) begin
      if (sel == AW'(i)) byte_out = sr_d[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q   <= '0;
      seen_q <= 1'b0;
      age_q  <= '0;
      tap_q  <= '0;
    end else begin
      sr_q   <= sr_d;
      seen_q <= seen_d;
      age_q  <= age_d;
      tap_q  <= tap_d;
    end
  end

endmodule

// File: rtl/s2p_lane_deskew.sv
// 4-lane deskew: finds COM on every lane, locks per-lane taps that cancel
// up to MAX_SKEW bytes of skew, emits one aligned 32-bit word per byte
// strobe while locked, and drops lock after ERR_LIMIT consecutive COM words
// that are only partly aligned.
//   CLK        clock
//   reset      synchronous active-high reset
//   bus        slave side of s2p_lane_deskew_if (inputs Q0..Q3/ENB/BYTE_VLD,
//              outputs DATA_OUT/VALID_OUT/LOCKED/ERR)
//   state_dbg  current supervisor state
module s2p_lane_deskew
  import s2p_lane_deskew_pkg::*;
#(
  parameter int         MAX_SKEW  = 3,
  parameter int         ERR_LIMIT = 2,
  parameter logic [7:0] COM       = COM_SYM
) (
  input  logic                  CLK,
  input  logic                  reset,
  s2p_lane_deskew_if.slave      bus,
  output state_e                state_dbg
);

  localparam int CW = cnt_width(ERR_LIMIT);

  state_e          state_q, state_d;
  logic [31:0]     data_q, data_d;
  logic            valid_q, valid_d;
  logic            err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [7:0]      lane_in   [NUM_LANES];
  logic [7:0]      lane_byte [NUM_LANES];
  logic [NUM_LANES-1:0] seen_new;
  logic [NUM_LANES-1:0] ovf;

  logic            strobe;
  logic            searching;
  logic            search_upd;
  logic            restart;
  logic            lock;
  logic            emit;
  logic            lose_lock;
  logic [2:0]      com_cnt;
  logic [31:0]     word;

  assign lane_in[0] = bus.Q0;
  assign lane_in[1] = bus.Q1;
  assign lane_in[2] = bus.Q2;
  assign lane_in[3] = bus.Q3;

  // reset has priority in the flops, so it need not appear in the strobe.
  assign strobe     = bus.BYTE_VLD & bus.ENB;
  assign searching  = (state_q == ST_SEARCH);
  assign search_upd = strobe & searching;
  assign restart    = |ovf;
  assign lock       = search_upd & (&seen_new);
  assign emit       = lock | (strobe & ~searching);

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    s2p_lane_buf #(
      .MAX_SKEW (MAX_SKEW),
      .COM      (COM)
    ) u_lane (
      .clk        (CLK),
      .reset      (reset),
      .strobe     (strobe),
      .search_upd (search_upd),
      .restart    (restart),
      .lock       (lock),
      .clr_seen   (lose_lock | lock),
      .q          (lane_in[n]),
      .seen_new   (seen_new[n]),
      .ovf        (ovf[n]),
      .byte_out   (lane_byte[n])
    );
  end

  always_comb begin
    word    = {lane_byte[3], lane_byte[2], lane_byte[1], lane_byte[0]};
    com_cnt = '0;
    for (int n = 0; n < NUM_LANES; n++) begin
      if (lane_byte[n] == COM) com_cnt = com_cnt + 3'd1;
    end

    state_d   = state_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    cnt_d     = cnt_q;
    lose_lock = 1'b0;

    if (lock) state_d = ST_LOCKED;

    if (emit) begin
      data_d  = word;
      valid_d = 1'b1;
      if (com_cnt == 3'd4) begin
        cnt_d = '0;
      end else if (com_cnt != 3'd0) begin
        // A partly aligned COM word is still delivered, flagged by ERR.
        err_d = 1'b1;
        if (int'(cnt_q) + 1 >= ERR_LIMIT) begin
          state_d   = ST_SEARCH;
          cnt_d     = '0;
          lose_lock = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= ST_SEARCH;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.DATA_OUT  = data_q;
  assign bus.VALID_OUT = valid_q;
  assign bus.ERR       = err_q;
  assign bus.LOCKED    = (state_q == ST_LOCKED);
  assign state_dbg     = state_q;

endmodule

// File: tb/tb_s2p_lane_deskew.sv
module tb_s2p_lane_deskew;
  import s2p_lane_deskew_pkg::*;

  localparam int MAX_SKEW  = 3;
  localparam int ERR_LIMIT = 2;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  state_e state_dbg;
  always #5 clk = ~clk;

  s2p_lane_deskew_if bus();

  s2p_lane_deskew #(
    .MAX_SKEW  (MAX_SKEW),
    .ERR_LIMIT (ERR_LIMIT),
    .COM       (COM_SYM)
  ) dut (
    .CLK       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .state_dbg (state_dbg)
  );

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic        locked;
    logic [31:0] data;
  } cyc_t;

  logic [32:0] exp_q[$];   // {err, word} for each expected VALID_OUT
  cyc_t        cyc_q[$];   // expected LOCKED / held DATA_OUT every cycle
  int n_checks = 0;
  int n_errors = 0;
  int valid_cnt = 0;
  int err_cnt = 0;

  task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Per-lane byte history; the aligned byte of lane n is the one received
  // tap[n] strobes ago.
  logic [7:0]  hist[4][$];
  bit          m_locked;
  bit          m_seen[4];
  int          m_age[4];
  int          m_tap[4];
  int          m_cnt;
  logic [31:0] m_data;

  function automatic void model_reset();
    m_locked = 0;
    m_cnt    = 0;
    m_data   = '0;
    for (int n = 0; n < 4; n++) begin
      m_seen[n] = 0; m_age[n] = 0; m_tap[n] = 0;
      hist[n].delete();
    end
  endfunction

  function automatic void model_step(input logic [3:0][7:0] q);
    bit ovf, all, e;
    int c, idx;
    logic [7:0] b;
    logic [31:0] w;
    for (int n = 0; n < 4; n++) begin
      hist[n].push_back(q[n]);
      if (hist[n].size() > 8) void'(hist[n].pop_front());
    end
    if (!m_locked) begin
      ovf = 0;
      for (int n = 0; n < 4; n++)
        if (m_seen[n] && m_age[n] + 1 > MAX_SKEW) ovf = 1;
      for (int n = 0; n < 4; n++) begin
        if (ovf) begin
          m_seen[n] = (q[n] == COM_SYM); m_age[n] = 0;
        end else if (m_seen[n]) begin
          m_age[n]++;
        end else if (q[n] == COM_SYM) begin
          m_seen[n] = 1; m_age[n] = 0;
        end
      end
      all = 1;
      for (int n = 0; n < 4; n++) all &= m_seen[n];
      if (!all) return;
      for (int n = 0; n < 4; n++) m_tap[n] = m_age[n];
      m_locked = 1;
    end
    c = 0;
    w = '0;
    for (int n = 0; n < 4; n++) begin
      idx = hist[n].size() - 1 - m_tap[n];
      b = (idx >= 0) ? hist[n][idx] : 8'h00;
      w[8*n +: 8] = b;
      if (b == COM_SYM) c++;
    end
    e = 0;
    if (c == 4) m_cnt = 0;
    else if (c > 0) begin
      e = 1;
      m_cnt++;
      if (m_cnt >= ERR_LIMIT) begin
        m_locked = 0;
        m_cnt = 0;
        for (int n = 0; n < 4; n++) begin m_seen[n] = 0; m_age[n] = 0; end
      end
    end
    m_data = w;
    exp_q.push_back({e, w});
  endfunction

  // ---------------- driver ----------------
  task automatic drive(input bit rst, input bit enb, input bit bv, input logic [3:0][7:0] q);
    @(negedge clk); #1;
    reset        = rst;
    bus.ENB      = enb;
    bus.BYTE_VLD = bv;
    bus.Q0 = q[0]; bus.Q1 = q[1]; bus.Q2 = q[2]; bus.Q3 = q[3];
    if (rst) model_reset();
    else if (enb && bv) model_step(q);
    cyc_q.push_back('{locked: m_locked, data: m_data});
  endtask

  function automatic logic [3:0][7:0] rand_q();
    return $urandom();
  endfunction

  int         skew[4];
  logic [7:0] base[$];

  function automatic void push_base();
    logic [7:0] v;
    if (base.size() % 8 == 0) v = COM_SYM;
    else begin
      v = 8'($urandom_range(0, 255));
      if (v == COM_SYM) v = 8'h00;
    end
    base.push_back(v);
  endfunction

  task automatic send_stream(input int n, input int gap_max, input bit enb_noise);
    logic [3:0][7:0] q;
    int idx;
    for (int i = 0; i < n; i++) begin
      push_base();
      for (int l = 0; l < 4; l++) begin
        idx  = base.size() - 1 - skew[l];
        q[l] = (idx >= 0) ? base[idx] : 8'h00;
      end
      drive(0, 1, 1, q);
      repeat ($urandom_range(0, gap_max)) begin
        if (enb_noise && $urandom_range(0, 3) == 0) drive(0, 0, 1, rand_q());
        else drive(0, 1, 0, rand_q());
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 1, 0, rand_q());
  endtask

  task automatic restart_all(input int s0, input int s1, input int s2, input int s3);
    drive(1, 1, 1, rand_q());
    skew[0] = s0; skew[1] = s1; skew[2] = s2; skew[3] = s3;
    base.delete();
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    cyc_t e;
    logic [32:0] w;
    if (cyc_q.size() > 0) begin
      e = cyc_q.pop_front();
      chk("locked", {32'd0, bus.LOCKED}, {32'd0, e.locked});
      chk("state_dbg", {32'd0, state_dbg}, {32'd0, e.locked ? ST_LOCKED : ST_SEARCH});
      chk("data_hold", {1'b0, bus.DATA_OUT}, {1'b0, e.data});
    end
    if (bus.VALID_OUT === 1'b1) begin
      valid_cnt++;
      if (bus.ERR === 1'b1) err_cnt++;
      if (exp_q.size() == 0) begin
        chk("unexpected_valid", {1'b0, bus.DATA_OUT}, 33'h1_0000_0000);
      end else begin
        w = exp_q.pop_front();
        chk("word", {bus.ERR, bus.DATA_OUT}, w);
      end
    end else if (bus.ERR === 1'b1) begin
      chk("err_without_valid", {32'd0, bus.ERR}, 33'd0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int v0, e0;
    reset = 1'b1;
    bus.ENB = 1'b0; bus.BYTE_VLD = 1'b0;
    bus.Q0 = '0; bus.Q1 = '0; bus.Q2 = '0; bus.Q3 = '0;
    model_reset();

    // 1: zero skew, directed bytes
    drive(1, 0, 0, '0);
    idle(1);
    chk("reset_data", {1'b0, bus.DATA_OUT}, 33'd0);
    chk("reset_locked", {32'd0, bus.LOCKED}, 33'd0);
    v0 = valid_cnt;
    drive(0, 1, 1, {4{COM_SYM}});
    for (int k = 1; k <= 8; k++) drive(0, 1, 1, {4{8'(k)}});
    idle(2);
    chk("t1_valid_count", 33'(valid_cnt - v0), 33'd9);
    chk("t1_locked", {32'd0, bus.LOCKED}, 33'd1);

    // 2: skew 0/1/2/3
    restart_all(0, 1, 2, 3);
    send_stream(30, 1, 0);
    idle(2);
    chk("t2_locked", {32'd0, bus.LOCKED}, 33'd1);

    // 3: skew 4 on lane3 is beyond reach
    restart_all(0, 0, 0, 4);
    idle(1);
    v0 = valid_cnt;
    send_stream(40, 1, 0);
    idle(2);
    chk("t3_no_valid", 33'(valid_cnt - v0), 33'd0);
    chk("t3_locked", {32'd0, bus.LOCKED}, 33'd0);

    // 4: lane1 slips one byte while locked
    restart_all(0, 0, 0, 0);
    send_stream(12, 0, 0);
    idle(2);
    e0 = err_cnt;
    skew[1] = 1;
    send_stream(40, 0, 0);
    idle(2);
    chk("t4_err_pulses", 33'(err_cnt - e0), 33'(ERR_LIMIT));
    chk("t4_relocked", {32'd0, bus.LOCKED}, 33'd1);

    // 5: enable low with strobes pulsing
    restart_all(0, 1, 1, 0);
    send_stream(12, 0, 0);
    idle(2);
    v0 = valid_cnt;
    repeat (5) drive(0, 0, 1, rand_q());
    idle(1);
    chk("t5_frozen_valid", 33'(valid_cnt - v0), 33'd0);
    send_stream(10, 0, 0);
    idle(2);
    chk("t5_resumed_locked", {32'd0, bus.LOCKED}, 33'd1);

    // 6: reset while locked
    drive(1, 1, 1, {4{COM_SYM}});
    idle(1);
    chk("t6_reset_locked", {32'd0, bus.LOCKED}, 33'd0);
    chk("t6_reset_data", {1'b0, bus.DATA_OUT}, 33'd0);
    skew[0] = 2; skew[1] = 0; skew[2] = 3; skew[3] = 1;
    base.delete();
    send_stream(20, 1, 0);

    // randomized skews, gaps and enable noise
    for (int it = 0; it < 6; it++) begin
      restart_all($urandom_range(0, 4), $urandom_range(0, 4),
                  $urandom_range(0, 4), $urandom_range(0, 4));
      send_stream(100, 2, 1);
      if ($urandom_range(0, 1) == 1) begin
        skew[$urandom_range(0, 3)] += 1;
        send_stream(40, 1, 1);
      end
    end

    idle(3);
    chk("exp_q_drained", 33'(exp_q.size()), 33'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
